// File: rtl/rv32im_mem_arbiter_pkg.sv
// Shared widths and encodings for the IFU/LSU memory arbiter.
package rv32im_mem_arbiter_pkg;

  localparam int API_ADDR_WIDTH = 32;
  localparam int API_DATA_WIDTH = 32;

  typedef enum logic {
    MEMARB_IDLE = 1'b0,
    MEMARB_BUSY = 1'b1
  } memarb_state_e;

  typedef enum logic {
    MEMARB_OWNER_IFU = 1'b0,
    MEMARB_OWNER_LSU = 1'b1
  } memarb_owner_e;

endpackage

// File: rtl/rv32im_arb_pick.sv
// Combinational grant decision: LSU has fixed priority unless the IFU has been starved.
module rv32im_arb_pick (
  input  logic       idle_i,
  input  logic       ifu_req_i,
  input  logic       lsu_req_i,
  input  logic [3:0] starve_i,
  input  logic [3:0] limit_i,
  output logic       ifu_gnt_o,
  output logic       lsu_gnt_o
);

  logic starved_s;

  assign starved_s = (starve_i == limit_i);

  always_comb begin
    ifu_gnt_o = 1'b0;
    lsu_gnt_o = 1'b0;
    if (idle_i) begin
      if (lsu_req_i && !(ifu_req_i && starved_s)) begin
        lsu_gnt_o = 1'b1;
      end else begin
        ifu_gnt_o = ifu_req_i;
      end
    end else begin
      ifu_gnt_o = 1'b0;
      lsu_gnt_o = 1'b0;
    end
  end

endmodule

// File: rtl/rv32im_mem_arbiter.sv
// Shares one memory port between IFU and LSU: one access at a time, rvalid one cycle after mem_ready.
module rv32im_mem_arbiter
  import rv32im_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      ifu_req_i,
  input  logic [API_ADDR_WIDTH-1:0] ifu_addr_i,
  output logic                      ifu_gnt_o,
  output logic                      ifu_rvalid_o,
  output logic [API_DATA_WIDTH-1:0] ifu_rdata_o,
  input  logic                      lsu_req_i,
  input  logic                      lsu_we_i,
  input  logic [API_ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [3:0]                lsu_wmask_i,
  input  logic [API_DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                      lsu_gnt_o,
  output logic                      lsu_rvalid_o,
  output logic [API_DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [API_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]                mem_wmask_o,
  output logic [API_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                      mem_ready_i,
  input  logic [API_DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  memarb_state_e             state_q, state_d;
  memarb_owner_e             owner_q, owner_d;
  logic [API_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [3:0]                wmask_q, wmask_d;
  logic [API_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]                starve_q, starve_d;
  logic [API_DATA_WIDTH-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [API_DATA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;
  logic                      ifu_rvalid_q, ifu_rvalid_d;
  logic                      lsu_rvalid_q, lsu_rvalid_d;
  logic                      idle_s, busy_s;

  // Grants must stay low while reset is held, even though the FSM already reads IDLE.
  assign idle_s = (state_q == MEMARB_IDLE) && rst_n_i;
  assign busy_s = (state_q == MEMARB_BUSY);

  rv32im_arb_pick u_pick (
    .idle_i    (idle_s),
    .ifu_req_i (ifu_req_i),
    .lsu_req_i (lsu_req_i),
    .starve_i  (starve_q),
    .limit_i   (LIMIT),
    .ifu_gnt_o (ifu_gnt_o),
    .lsu_gnt_o (lsu_gnt_o)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    ifu_rdata_d  = ifu_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    ifu_rvalid_d = 1'b0;
    lsu_rvalid_d = 1'b0;
    case (state_q)
      MEMARB_IDLE: begin
        if (lsu_gnt_o) begin
          state_d = MEMARB_BUSY;
          owner_d = MEMARB_OWNER_LSU;
          addr_d  = {lsu_addr_i[API_ADDR_WIDTH-1:2], 2'b00};
          we_d    = lsu_we_i;
          wmask_d = lsu_we_i ? lsu_wmask_i : 4'b0000;
          wdata_d = lsu_wdata_i;
        end else if (ifu_gnt_o) begin
          state_d = MEMARB_BUSY;
          owner_d = MEMARB_OWNER_IFU;
          addr_d  = {ifu_addr_i[API_ADDR_WIDTH-1:2], 2'b00};
          we_d    = 1'b0;
          wmask_d = 4'b0000;
          wdata_d = '0;
        end else begin
          state_d = MEMARB_IDLE;
        end
      end
      MEMARB_BUSY: begin
        if (mem_ready_i) begin
          state_d = MEMARB_IDLE;
          if (owner_q == MEMARB_OWNER_IFU) begin
            ifu_rvalid_d = 1'b1;
            ifu_rdata_d  = mem_rdata_i;
          end else begin
            lsu_rvalid_d = 1'b1;
            lsu_rdata_d  = we_q ? lsu_rdata_q : mem_rdata_i;
          end
        end else begin
          state_d = MEMARB_BUSY;
        end
      end
      default: state_d = MEMARB_IDLE;
    endcase
  end

  always_comb begin
    if (ifu_gnt_o) begin
      starve_d = 4'd0;
    end else if (lsu_gnt_o && ifu_req_i && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= MEMARB_IDLE;
      owner_q      <= MEMARB_OWNER_IFU;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wmask_q      <= 4'b0000;
      wdata_q      <= '0;
      starve_q     <= 4'd0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wmask_q      <= wmask_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
      ifu_rvalid_q <= ifu_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
    end
  end

  assign mem_en_o     = busy_s;
  assign mem_we_o     = busy_s & we_q;
  assign mem_addr_o   = busy_s ? addr_q : '0;
  assign mem_wmask_o  = busy_s ? wmask_q : 4'b0000;
  assign mem_wdata_o  = busy_s ? wdata_q : '0;
  assign ifu_rvalid_o = ifu_rvalid_q;
  assign ifu_rdata_o  = ifu_rdata_q;
  assign lsu_rvalid_o = lsu_rvalid_q;
  assign lsu_rdata_o  = lsu_rdata_q;

endmodule

// File: tb/tb_rv32im_mem_arbiter.sv
// Directed self-checking bench for rv32im_mem_arbiter (STARVE_LIMIT = 4).
module tb_rv32im_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o;
  logic        ifu_rvalid_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [3:0]  lsu_wmask_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  int tests_run = 0;
  int tests_failed = 0;

  rv32im_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .ifu_req_i    (ifu_req_i),
    .ifu_addr_i   (ifu_addr_i),
    .ifu_gnt_o    (ifu_gnt_o),
    .ifu_rvalid_o (ifu_rvalid_o),
    .ifu_rdata_o  (ifu_rdata_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wmask_i  (lsu_wmask_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wmask_o  (mem_wmask_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Move to the start of the next cycle (just after the rising edge).
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_i   = 1'b0;
    ifu_addr_i  = 32'h0;
    lsu_req_i   = 1'b0;
    lsu_we_i    = 1'b0;
    lsu_addr_i  = 32'h0;
    lsu_wmask_i = 4'b0000;
    lsu_wdata_i = 32'h0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_i   = 1'b0;
    ifu_req_i = 1'b1;
    lsu_req_i = 1'b1;
    tick();
    tick();
    @(negedge clk_i);
    tests_run++;
    if ({ifu_gnt_o, lsu_gnt_o, ifu_rvalid_o, lsu_rvalid_o, mem_en_o, mem_we_o} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 000000", {ifu_gnt_o, lsu_gnt_o, ifu_rvalid_o, lsu_rvalid_o, mem_en_o, mem_we_o});
    end
    tests_run++;
    if ({mem_addr_o, mem_wmask_o, mem_wdata_o, ifu_rdata_o, lsu_rdata_o} !== 132'h0) begin
      tests_failed++;
      $display("FAIL reset_data: addr %h mask %b wdata %h irdata %h lrdata %h required all 0", mem_addr_o, mem_wmask_o, mem_wdata_o, ifu_rdata_o, lsu_rdata_o);
    end
    tick();
    rst_n_i = 1'b1;
    #1;
    tests_run++;
    if (lsu_gnt_o !== 1'b1 || ifu_gnt_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_grant: lsu_gnt %b ifu_gnt %b required 1 0", lsu_gnt_o, ifu_gnt_o);
    end
    tick();
    idle_inputs();
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_ifu_read();
    apply_reset();
    ifu_req_i  = 1'b1;
    ifu_addr_i = 32'h0000_0104;
    @(negedge clk_i);
    tests_run++;
    if (ifu_gnt_o !== 1'b1 || lsu_gnt_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ifu_grant: ifu_gnt %b lsu_gnt %b required 1 0", ifu_gnt_o, lsu_gnt_o);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      ifu_req_i   = 1'b0;
      ifu_addr_i  = 32'hFFFF_FFFF;
      mem_ready_i = (c == 3);
      mem_rdata_i = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      @(negedge clk_i);
      tests_run++;
      if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h0000_0104 || mem_we_o !== 1'b0 || mem_wmask_o !== 4'b0000 || ifu_rvalid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL ifu_busy_c%0d: en %b addr %h we %b mask %b rvalid %b required 1 00000104 0 0000 0", c, mem_en_o, mem_addr_o, mem_we_o, mem_wmask_o, ifu_rvalid_o);
      end
    end
    tick();
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    @(negedge clk_i);
    tests_run++;
    if (ifu_rvalid_o !== 1'b1 || ifu_rdata_o !== 32'hDEAD_BEEF || lsu_rvalid_o !== 1'b0 || mem_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ifu_rvalid: rvalid %b rdata %h lsu_rvalid %b en %b required 1 deadbeef 0 0", ifu_rvalid_o, ifu_rdata_o, lsu_rvalid_o, mem_en_o);
    end
    tick();
    @(negedge clk_i);
    tests_run++;
    if (ifu_rvalid_o !== 1'b0 || ifu_rdata_o !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL ifu_rvalid_pulse: rvalid %b rdata %h required 0 deadbeef", ifu_rvalid_o, ifu_rdata_o);
    end
  endtask

  task automatic test_lsu_write();
    apply_reset();
    lsu_req_i  = 1'b1;
    lsu_addr_i = 32'h0000_0300;
    tick();
    lsu_req_i   = 1'b0;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h1234_5678;
    tick();
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL lsu_read: rvalid %b rdata %h required 1 12345678", lsu_rvalid_o, lsu_rdata_o);
    end
    tick();
    lsu_req_i   = 1'b1;
    lsu_we_i    = 1'b1;
    lsu_addr_i  = 32'h0000_0202;
    lsu_wmask_i = 4'b0100;
    lsu_wdata_i = 32'h00AB_0000;
    @(negedge clk_i);
    tests_run++;
    if (lsu_gnt_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL lsu_write_grant: lsu_gnt %b required 1", lsu_gnt_o);
    end
    tick();
    idle_inputs();
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    tests_run++;
    if (mem_en_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_0200 || mem_wmask_o !== 4'b0100 || mem_wdata_o !== 32'h00AB_0000) begin
      tests_failed++;
      $display("FAIL lsu_write_mem: en %b we %b addr %h mask %b wdata %h required 1 1 00000200 0100 00ab0000", mem_en_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o);
    end
    tick();
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'h1234_5678 || mem_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL lsu_write_done: rvalid %b rdata %h en %b required 1 12345678 0", lsu_rvalid_o, lsu_rdata_o, mem_en_o);
    end
  endtask

  task automatic test_contention();
    logic exp_lsu [0:10];
    int   g;
    // Expected winners: 1 = LSU, 0 = IFU.
    exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    g = 0;
    apply_reset();
    ifu_req_i   = 1'b1;
    ifu_addr_i  = 32'h0000_0040;
    lsu_req_i   = 1'b1;
    lsu_addr_i  = 32'h0000_0080;
    mem_ready_i = 1'b1;
    for (int c = 0; c < 40 && g < 11; c++) begin
      @(negedge clk_i);
      if (ifu_gnt_o && lsu_gnt_o) begin
        tests_run++;
        tests_failed++;
        $display("FAIL contention_both_gnt: cycle %0d both grants high required at most one", c);
      end else if (ifu_gnt_o || lsu_gnt_o) begin
        tests_run++;
        if (lsu_gnt_o !== exp_lsu[g]) begin
          tests_failed++;
          $display("FAIL contention_order_%0d: lsu_gnt %b required %b", g, lsu_gnt_o, exp_lsu[g]);
        end
        g++;
      end
      tick();
    end
    if (g < 11) begin
      tests_run++;
      tests_failed++;
      $display("FAIL contention_timeout: saw %0d grants required 11", g);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int rv_seen;
    rv_seen = 0;
    apply_reset();
    ifu_req_i   = 1'b1;
    lsu_req_i   = 1'b1;
    mem_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
    end
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (lsu_gnt_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_4th_grant: lsu_gnt %b required 1", lsu_gnt_o);
    end
    tick();
    ifu_req_i = 1'b0;
    lsu_req_i = 1'b0;
    tests_run++;
    if (mem_en_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_busy: mem_en %b required 1", mem_en_o);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    tests_run++;
    if (mem_en_o !== 1'b0 || dut.starve_q !== 4'd0) begin
      tests_failed++;
      $display("FAIL midrst_drop: mem_en %b starve %0d required 0 0", mem_en_o, dut.starve_q);
    end
    mem_ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (lsu_rvalid_o || ifu_rvalid_o) rv_seen++;
    end
    mem_ready_i = 1'b0;
    ifu_req_i   = 1'b1;
    lsu_req_i   = 1'b1;
    rst_n_i     = 1'b1;
    #1;
    tests_run++;
    if (lsu_gnt_o !== 1'b1 || ifu_gnt_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_starve_cleared: lsu_gnt %b ifu_gnt %b required 1 0", lsu_gnt_o, ifu_gnt_o);
    end
    tick();
    ifu_req_i = 1'b0;
    lsu_req_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (lsu_rvalid_o || ifu_rvalid_o) rv_seen++;
      tick();
    end
    tests_run++;
    if (rv_seen != 0) begin
      tests_failed++;
      $display("FAIL midrst_no_rvalid: saw %0d rvalid cycles required 0", rv_seen);
    end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    lsu_req_i   = 1'b1;
    lsu_addr_i  = 32'h0000_0010;
    mem_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      mem_rdata_i = 32'h0000_0100 + 32'(c);
      @(negedge clk_i);
      tests_run++;
      if (lsu_gnt_o !== (c % 2 == 0) || lsu_rvalid_o !== (c >= 2 && c % 2 == 0)) begin
        tests_failed++;
        $display("FAIL b2b_c%0d: gnt %b rvalid %b required %b %b", c, lsu_gnt_o, lsu_rvalid_o, (c % 2 == 0), (c >= 2 && c % 2 == 0));
      end
      if (c >= 2 && c % 2 == 0) begin
        tests_run++;
        if (lsu_rdata_o !== 32'h0000_0100 + 32'(c - 1)) begin
          tests_failed++;
          $display("FAIL b2b_rdata_c%0d: rdata %h required %h", c, lsu_rdata_o, 32'h0000_0100 + 32'(c - 1));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n_i = 1'b0;
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rv32im_mem_arbiter.md
# rv32im_mem_arbiter

Two-port arbiter and sequencer that shares the single data/instruction memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Accepts one request at a time, holds the memory interface stable until the memory acknowledges, and returns read data or write completion to the winning requester one cycle later. The LSU has fixed priority. A starvation counter forces an IFU grant after a bounded number of consecutive LSU wins. Sits between `rv32im_lsu`/IFU and the memory model.

## Interface
- `STARVE_LIMIT`, 4: consecutive contested LSU wins after which the IFU is granted (1..15).
- `clk_i` in 1: clock, rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `ifu_req_i` in 1: IFU read request.
- `ifu_addr_i` in `API_ADDR_WIDTH`: IFU word address.
- `ifu_gnt_o` out 1: IFU request accepted this cycle.
- `ifu_rvalid_o` out 1: one-cycle pulse; `ifu_rdata_o` valid.
- `ifu_rdata_o` out `API_DATA_WIDTH`: fetched word.
- `lsu_req_i` in 1: LSU request.
- `lsu_we_i` in 1: 1 = write.
- `lsu_addr_i` in `API_ADDR_WIDTH`: word-aligned address from the LSU.
- `lsu_wmask_i` in 4: byte write mask.
- `lsu_wdata_i` in `API_DATA_WIDTH`: write data.
- `lsu_gnt_o` out 1: LSU request accepted this cycle.
- `lsu_rvalid_o` out 1: one-cycle completion pulse for reads and writes.
- `lsu_rdata_o` out `API_DATA_WIDTH`: load word. Unchanged on write completion.
- `mem_en_o` out 1: memory access active.
- `mem_we_o` out 1: write strobe.
- `mem_addr_o` out `API_ADDR_WIDTH`: address with bits [1:0] forced to 00.
- `mem_wmask_o` out 4: byte mask. 0000 on reads.
- `mem_wdata_o` out `API_DATA_WIDTH`: write data.
- `mem_ready_i` in 1: memory completes the access this cycle. `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i` in `API_DATA_WIDTH`: read data.

## Operation
- **FSM states:** IDLE, BUSY.
- **IDLE:**
  - Grant logic is combinational from the requests and `starve_q`. At most one of `ifu_gnt_o`/`lsu_gnt_o` is high.
  - Only LSU requesting: grant LSU. Only IFU requesting: grant IFU.
  - Both requesting: grant LSU unless `starve_q == STARVE_LIMIT`, in which case grant IFU.
  - On a grant, capture owner, address, we, mask and wdata into registers, then go to BUSY.
- **BUSY:**
  - Drive `mem_en_o`=1 and all `mem_*` outputs from the capture registers. They stay stable until `mem_ready_i`.
  - Grants are 0 in BUSY. Requests arriving while BUSY wait and are not queued.
  - On `mem_ready_i`: latch `mem_rdata_i` into the owner's rdata register (reads only), schedule the owner's rvalid pulse, and return to IDLE.
- **Starvation counter `starve_q`:** 4 bits.
  - Increments, saturating at `STARVE_LIMIT`, on an LSU grant while `ifu_req_i`=1.
  - Clears on any IFU grant.
  - Otherwise holds.
- **Requester contract:** a requester holds its request until granted. After the grant it does not need to hold the request.
- **Reset:** reset during BUSY abandons the access. No rvalid is issued, and requesters re-request.
- **Reset values:** all outputs 0, rdata registers 0, FSM in IDLE, `starve_q`=0.

## Timing
- Request in IDLE at cycle 0: grant in cycle 0, `mem_en_o` from cycle 1.
- `mem_ready_i` at cycle k ≥ 1: rvalid at k+1, with rdata valid at k+1.
- The FSM is in IDLE at k+1, so a new grant is possible at k+1. Back-to-back accesses therefore take 2 cycles each for zero-wait memory.
- `mem_ready_i` while IDLE is ignored.
- rvalid pulses are exactly one cycle. Each grant produces exactly one pulse (barring reset).
- `*_rdata_o` holds its value until the next read completion for that port.

## Structure
- Add `MEMARB_IDLE`/`MEMARB_BUSY` state encodings and the `MEMARB_OWNER_IFU`/`MEMARB_OWNER_LSU` encodings to `DEFINITIONS.v`, next to the `LSU_OPCODE_*` defines.
- Widths come from `API_ADDR_WIDTH`/`API_DATA_WIDTH`.
- One sub-module, `rv32im_arb_pick`: the combinational priority/starvation grant decision. It takes the two requests, `starve_q`, `STARVE_LIMIT` and the IDLE flag, and outputs the two grants. Counter, FSM and capture registers live in the top module.

## Test plan
- **Reset:** hold `rst_n_i`=0 with both requests high → all outputs 0, no grants. Release, and IDLE grants LSU in the same cycle.
- **IFU read:** IFU read of 0x0000_0104 with memory ready after 3 cycles returning 0xDEAD_BEEF →
  - `ifu_gnt_o` at cycle 0;
  - `mem_addr_o`=0x0000_0104 and `mem_en_o` high at cycles 1–3;
  - `ifu_rvalid_o` at cycle 4 with 0xDEAD_BEEF.
- **LSU write:** LSU write, mask 0100, data 0x00AB_0000, address 0x0000_0202 → `mem_addr_o`=0x0000_0200, `mem_wmask_o`=0100, `mem_we_o`=1. Then `lsu_rvalid_o` pulses while `lsu_rdata_o` is unchanged.
- **Contention with starvation:** both requesting continuously, STARVE_LIMIT=4, zero-wait memory → grant order LSU, LSU, LSU, LSU, IFU, LSU, ….
- **Reset mid-access:** assert `rst_n_i` low during BUSY before `mem_ready_i` → no rvalid, `mem_en_o` drops immediately, and `starve_q` is cleared.
- **Back-to-back:** `mem_ready_i` held at 1 with the LSU re-requesting → a grant every 2 cycles and `lsu_rvalid_o` every 2 cycles.
